// File: rtl/scan_pkg.sv
// +----------------------------------------------------------------------+
// | scan_pkg : shared state encoding and channel geometry for the scan   |
// | select sequencer.             Revision: 1.0                          |
// +----------------------------------------------------------------------+
`default_nettype none

package scan_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_BLANK  = 2'd1;
  localparam state_t ST_ACTIVE = 2'd2;

endpackage : scan_pkg

`default_nettype wire

// File: rtl/next_ch_find.sv
// +----------------------------------------------------------------------+
// | next_ch_find : lowest enabled channel strictly above i_cur, falling  |
// | back to the lowest enabled channel overall.  Revision: 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module next_ch_find
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0]  i_cur,
  input  logic [NUM_CH-1:0] i_mask,
  output logic [SEL_W-1:0]  o_nxt,
  output logic              o_wrap,
  output logic              o_none
);

  logic [SEL_W-1:0] w_lo;
  logic [SEL_W-1:0] w_hi;
  logic             w_has_hi;

  // Scanning downward leaves the lowest qualifying index in each result.
  always_comb begin
    w_lo     = '0;
    w_hi     = '0;
    w_has_hi = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        w_lo = SEL_W'(i);
        if (SEL_W'(i) > i_cur) begin
          w_hi     = SEL_W'(i);
          w_has_hi = 1'b1;
        end
      end
    end
  end

  assign o_nxt  = w_has_hi ? w_hi : w_lo;
  assign o_wrap = ~w_has_hi;
  assign o_none = ~|i_mask;

endmodule : next_ch_find

`default_nettype wire

// File: rtl/scan_sel_seq.sv
// +----------------------------------------------------------------------+
// | scan_sel_seq : 3-bit channel select sequencer for a 3-to-8 decoder,  |
// | dwell timing, single/continuous sweeps. Macro SCAN_BLANK_EN inserts  |
// | a one-cycle blank before every active period.  Revision: 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module scan_sel_seq
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_single,
  input  logic [NUM_CH-1:0]  i_ch_mask,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_sel_en,
  output logic               o_busy,
  output logic               o_sweep_done
);

`ifdef SCAN_BLANK_EN
  localparam state_t ST_ENTRY = ST_BLANK;
`else
  localparam state_t ST_ENTRY = ST_ACTIVE;
`endif

  state_t             r_state, w_state_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_single, w_single_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic               r_sel_en, w_sel_en_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_sweep_done, w_sweep_done_nxt;

  logic [SEL_W-1:0]   w_cur, w_nxt;
  logic               w_wrap, w_none;
  logic               w_last, w_sweep_end, w_accept, w_advance;
  logic [DWELL_W-1:0] w_dwell_eff;

  // In IDLE, searching above the top channel always wraps to the lowest set bit.
  assign w_cur = (r_state == ST_IDLE) ? SEL_W'(NUM_CH - 1) : r_sel;

  next_ch_find u_find (
    .i_cur  (w_cur),
    .i_mask (i_ch_mask),
    .o_nxt  (w_nxt),
    .o_wrap (w_wrap),
    .o_none (w_none)
  );

  assign w_dwell_eff = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
  assign w_last      = (r_cnt == DWELL_W'(1));
  assign w_sweep_end = w_wrap | w_none;
  assign w_accept    = (r_state == ST_IDLE) & i_start & ~i_stop & ~w_none;
  assign w_advance   = (r_state == ST_ACTIVE) & ~i_stop & w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_single     <= 1'b0;
      r_sel        <= '0;
      r_sel_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_sweep_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_single     <= w_single_nxt;
      r_sel        <= w_sel_nxt;
      r_sel_en     <= w_sel_en_nxt;
      r_busy       <= w_busy_nxt;
      r_sweep_done <= w_sweep_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_ENTRY;
      end
      ST_BLANK: begin
        w_state_nxt = i_stop ? ST_IDLE : ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (i_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          if (w_sweep_end && (r_single || w_none)) w_state_nxt = ST_IDLE;
          else                                     w_state_nxt = ST_ENTRY;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sel_nxt = r_sel;
    if (w_accept || (w_advance && (w_state_nxt != ST_IDLE))) w_sel_nxt = w_nxt;

    w_single_nxt = w_accept ? i_single : r_single;

    // Dwell is captured only when an active period begins.
    w_cnt_nxt = r_cnt;
    if ((w_state_nxt == ST_ACTIVE) && ((r_state != ST_ACTIVE) || w_last))
      w_cnt_nxt = w_dwell_eff;
    else if (w_state_nxt == ST_IDLE)
      w_cnt_nxt = '0;
    else if (r_state == ST_ACTIVE)
      w_cnt_nxt = r_cnt - DWELL_W'(1);

    w_sel_en_nxt     = (w_state_nxt == ST_ACTIVE);
    w_busy_nxt       = (w_state_nxt != ST_IDLE);
    w_sweep_done_nxt = w_advance & w_sweep_end;
  end

  assign o_sel        = r_sel;
  assign o_sel_en     = r_sel_en;
  assign o_busy       = r_busy;
  assign o_sweep_done = r_sweep_done;

endmodule : scan_sel_seq

`default_nettype wire

// File: tb/tb_scan_sel_seq.sv
// +----------------------------------------------------------------------+
// | tb_scan_sel_seq : directed + random bench for scan_sel_seq, checked  |
// | against a cycle-level behavioural model.     Revision: 1.0           |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_scan_sel_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start, i_stop, i_single;
  logic [7:0] i_ch_mask;
  logic [7:0] i_dwell;
  logic [2:0] o_sel;
  logic       o_sel_en, o_busy, o_sweep_done;

  int n_checks = 0;
  int n_errors = 0;

  // model state: scanning flag, gap flag, active cycles left, channel, mode
  bit m_busy, m_blank, m_single, m_done;
  int m_left, m_sel;

  always #5 clk = ~clk;

  scan_sel_seq #(.DWELL_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_single     (i_single),
    .i_ch_mask    (i_ch_mask),
    .i_dwell      (i_dwell),
    .o_sel        (o_sel),
    .o_sel_en     (o_sel_en),
    .o_busy       (o_busy),
    .o_sweep_done (o_sweep_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dwell_cycles();
    return (i_dwell == 0) ? 1 : int'(i_dwell);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_blank = 0; m_single = 0; m_done = 0; m_left = 0; m_sel = 0;
  endtask

  task automatic enter_channel();
`ifdef SCAN_BLANK_EN
    m_blank = 1;
`else
    m_blank = 0;
    m_left  = dwell_cycles();
`endif
  endtask

  // One clock edge of the reference behaviour, using the inputs present at the edge.
  task automatic model_step();
    int  nxt;
    bit  wrapped;
    m_done = 0;
    if (!m_busy) begin
      if (i_start && !i_stop && i_ch_mask != 0) begin
        for (int i = 7; i >= 0; i--) if (i_ch_mask[i]) m_sel = i;
        m_single = i_single;
        m_busy   = 1;
        enter_channel();
      end
    end else if (i_stop) begin
      m_busy = 0; m_blank = 0; m_left = 0;
    end else if (m_blank) begin
      m_blank = 0;
      m_left  = dwell_cycles();
    end else begin
      m_left--;
      if (m_left == 0) begin
        nxt = m_sel; wrapped = 1;
        for (int k = 8; k >= 1; k--) begin
          if (i_ch_mask[(m_sel + k) % 8]) begin
            nxt     = (m_sel + k) % 8;
            wrapped = (m_sel + k) >= 8;
          end
        end
        m_done = wrapped || (i_ch_mask == 0);
        if (m_done && (m_single || i_ch_mask == 0)) begin
          m_busy = 0;
        end else begin
          m_sel = nxt;
          enter_channel();
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("sel",        32'(o_sel),        32'(m_sel));
    chk("sel_en",     32'(o_sel_en),     32'(m_busy && !m_blank));
    chk("busy",       32'(o_busy),       32'(m_busy));
    chk("sweep_done", 32'(o_sweep_done), 32'(m_done));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic set_in(input bit st, input bit sp, input bit sg, input logic [7:0] mk, input logic [7:0] dw);
    i_start = st; i_stop = sp; i_single = sg; i_ch_mask = mk; i_dwell = dw;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_sel",    32'(o_sel),        32'd0);
    chk("rst_sel_en", 32'(o_sel_en),     32'd0);
    chk("rst_busy",   32'(o_busy),       32'd0);
    chk("rst_done",   32'(o_sweep_done), 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit hit;
    model_reset();
    set_in(0, 0, 0, 8'h00, 8'd0);
    rst_n = 1'b0;
    #2;
    chk("por_busy", 32'(o_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // idle after reset, then start with an empty mask
    repeat (20) tick();
    set_in(1, 0, 0, 8'h00, 8'd3);
    tick();
    set_in(0, 0, 0, 8'h00, 8'd3);
    repeat (3) tick();

    // continuous full-mask scan, dwell 3
    set_in(1, 0, 0, 8'hFF, 8'd3);
    tick();
    i_start = 0;
    repeat (70) tick();

    // stop and start together on the final cycle of channel 4
    hit = 0;
    for (int n = 0; n < 100 && !hit; n++) begin
      if (m_busy && !m_blank && m_sel == 4 && m_left == 1) hit = 1;
      else tick();
    end
    chk("reach_ch4_last", 32'(hit), 32'd1);
    i_start = 1; i_stop = 1;
    tick();
    chk("stop_sel",  32'(o_sel),        32'd4);
    chk("stop_en",   32'(o_sel_en),     32'd0);
    chk("stop_done", 32'(o_sweep_done), 32'd0);
    i_start = 0; i_stop = 0;
    repeat (3) tick();

    // masked single sweep, dwell 0 treated as 1
    set_in(1, 0, 1, 8'b1010_0100, 8'd0);
    tick();
    i_start = 0;
    repeat (12) tick();

    // mask shrinks to channel 0 while channel 3 is active; dwell change mid-period
    set_in(1, 0, 0, 8'hFF, 8'd5);
    tick();
    i_start = 0;
    hit = 0;
    for (int n = 0; n < 100 && !hit; n++) begin
      if (m_busy && !m_blank && m_sel == 3 && m_left == 5) hit = 1;
      else tick();
    end
    chk("reach_ch3", 32'(hit), 32'd1);
    i_ch_mask = 8'h01; i_dwell = 8'd1;
    repeat (12) tick();

    // asynchronous reset while scanning
    async_reset();
    repeat (3) tick();

    // random stimulus
    set_in(0, 0, 0, 8'hFF, 8'd2);
    for (int n = 0; n < 3000; n++) begin
      i_start  = ($urandom_range(0, 7) == 0);
      i_stop   = ($urandom_range(0, 63) == 0);
      i_single = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0:       i_ch_mask = 8'h00;
          1:       i_ch_mask = 8'(1 << $urandom_range(0, 7));
          default: i_ch_mask = 8'($urandom);
        endcase
      end
      i_dwell = 8'($urandom_range(0, 4));
      tick();
      if (n == 1500) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_scan_sel_seq

`default_nettype wire

// File: doc/scan_sel_seq.md
Name: scan_sel_seq

Overview:
- Sequencer that drives the 3-to-8 decoder stage.
- Generates the registered 3-bit channel select `sel` and its enable `sel_en`.
- Steps through the unmasked channels in ascending order with wrap. Each channel is held for a programmable dwell time.
- Supports continuous or single-sweep operation and optional blanking between channels. Typical uses are display digit scanning and strobed output banks.

Parameters:
- DWELL_W, 8, width of the dwell-time input and internal dwell counter.

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin scanning; sampled only in IDLE
- stop  input  1  abort scan; returns to IDLE at the next edge
- single  input  1  1 = one sweep then IDLE; 0 = continuous; sampled with start
- ch_mask  input  8  bit i = 1 means channel i participates; sampled at each channel advance
- dwell  input  DWELL_W  cycles each channel stays enabled; 0 is treated as 1; sampled on entry to ACTIVE
- sel  output  3  channel index to the decoder `in`
- sel_en  output  1  decoder enable; high only in ACTIVE
- busy  output  1  high in any state other than IDLE
- sweep_done  output  1  one-cycle pulse when the last enabled channel of a sweep finishes

Behaviour:
- Reset values: `sel`=3'd0, `sel_en`=0, `busy`=0, `sweep_done`=0; state=IDLE; dwell counter=0; single latch=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, BLANK, ACTIVE.
- IDLE:
  - On `start`=1 with `ch_mask`!=0 and `stop`=0: `sel` <= lowest set bit of `ch_mask`, latch `single`, go to BLANK.
  - `start` with `ch_mask`==0 is ignored; the block stays in IDLE.
- BLANK:
  - Lasts exactly 1 cycle with `sel_en`=0 and `sel` already at the new channel.
  - Then go to ACTIVE and load the counter with max(`dwell`,1).
- ACTIVE:
  - `sel_en`=1. The counter decrements each cycle, so ACTIVE lasts exactly max(`dwell`,1) cycles.
  - On the final cycle (counter==1), compute the next channel: the lowest set bit of `ch_mask` strictly above `sel`; if none, wrap to the lowest set bit overall.
- Sweep completion:
  - A sweep is complete when the next channel index is <= the current index (wrap), or when `ch_mask` has become 0.
  - On completion, pulse `sweep_done` for 1 cycle, coincident with leaving ACTIVE.
  - If latched single=1 or `ch_mask`==0, go to IDLE; otherwise update `sel` and go to BLANK.
- Single enabled channel: wraps to itself, so `sweep_done` pulses after every dwell period.
- Latency: `start` sampled at edge N gives BLANK after N and `sel_en`=1 after N+1.
- `stop`:
  - Has priority over everything, including a simultaneous `start` and the final ACTIVE cycle.
  - Next state is IDLE, `sel_en`=0, no `sweep_done` pulse, and `sel` holds its last value.
- `start` while `busy`=1 is ignored.
- Changes to `dwell` during ACTIVE do not affect the current channel.
- Changes to `ch_mask` take effect only at the next advance. The current channel completes even if its mask bit is cleared.
- Reset asserted mid-operation immediately forces all reset values, independent of `clk`.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined: the BLANK state is inserted before every ACTIVE period, as described above.
- Undefined:
  - BLANK is removed. IDLE goes directly to ACTIVE, and ACTIVE goes directly to ACTIVE on advance.
  - `sel` and `sel_en` change on the same edge, with no gap cycle.
  - Start latency becomes 1 cycle (`sel_en`=1 after edge N).
  - All other rules are unchanged.

Decomposition:
- Shared package `scan_pkg`:
  - state enum constants ST_IDLE, ST_BLANK, ST_ACTIVE (2-bit encoding);
  - NUM_CH=8 and SEL_W=3.
- One natural sub-module: `next_ch_find`, combinational. Takes (cur[2:0], mask[7:0]) and returns (nxt[2:0], wrap, none). It is used both for the first-channel search (cur treated as "below 0") and for each advance.

Test Plan:
- Reset/idle: `rst_n` low then high, no `start` → `sel`=0, `sel_en`=0, `busy`=0 for 20 cycles. `start` with `ch_mask`=8'h00 → `busy` stays 0.
- Continuous scan, blanking on: `ch_mask`=8'hFF, `dwell`=3, `single`=0, `start` for 1 cycle → `sel_en` high 3 cycles, low 1, repeating; `sel` steps 0,1,...,7,0. `sweep_done` pulses once per 32 cycles on leaving channel 7.
- Masked single sweep: `ch_mask`=8'b1010_0100, `dwell`=0, `single`=1 → ACTIVE for 1 cycle each on `sel`=2,5,7. `sweep_done` pulses on leaving 7, then `busy`=0.
- Stop priority: during ACTIVE on `sel`=4 with counter==1, assert `stop` and `start` together → next cycle IDLE, `sel_en`=0, `sweep_done`=0, `sel`=4.
- Mid-run changes: `ch_mask` cleared to 8'h01 while ACTIVE on channel 3 with `dwell`=5 → channel 3 completes its 5 cycles, then wrap to 0 with a `sweep_done` pulse. Changing `dwell` mid-ACTIVE does not shorten the current period.
- Async reset mid-ACTIVE: drop `rst_n` between clock edges → outputs go to reset values immediately. Repeat all scenarios with SCAN_BLANK_EN undefined and check zero-gap `sel_en` and 1-cycle start latency.
